// File: rtl/access_control_pkg.sv
// access_control_pkg: shared states, request encodings and status frame layout
package access_control_pkg;
  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, GRANTED, NEW_COLLECT, LOCKED} state_e;
  localparam logic [1:0] REQ_NONE   = 2'b00;
  localparam logic [1:0] REQ_LOGIN  = 2'b01;
  localparam logic [1:0] REQ_CHANGE = 2'b10;
  localparam logic [1:0] REQ_LOGOUT = 2'b11;
  localparam int SF_GRANT = 0;
  localparam int SF_BUSY  = 1;
  localparam int SF_LOCK  = 2;
endpackage

// File: rtl/access_pw_store.sv
// access_pw_store: per-user password registers, preloaded on reset, async read
module access_pw_store
  import access_control_pkg::*;
#(
  parameter int              USERS      = 4,
  parameter int              PW_W       = 16,
  parameter int              UID_W      = 2,
  parameter logic [PW_W-1:0] DEFAULT_PW = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [UID_W-1:0] waddr_i,
  input  logic [PW_W-1:0]  wdata_i,
  input  logic [UID_W-1:0] raddr_i,
  output logic [PW_W-1:0]  rdata_o
);
  logic [PW_W-1:0] mem_q [USERS];
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: DEFAULT_PW};
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/access_control_multi.sv
// access_control_multi: multi-user digit-serial login with lockout and password change
// Define ACCESS_TIMEOUT_EN to abort digit entry after TIMEOUT_CYCLES idle cycles.
module access_control_multi
  import access_control_pkg::*;
#(
  parameter int                         DIGIT_W        = 4,
  parameter int                         DIGITS         = 4,
  parameter int                         USERS          = 4,
  parameter int                         UID_W          = (USERS > 1) ? $clog2(USERS) : 1,
  parameter logic [DIGIT_W*DIGITS-1:0]  DEFAULT_PW     = 16'h1234,
  parameter int                         MAX_FAILS      = 3,
  parameter int                         LOCK_CYCLES    = 1000,
  parameter int                         TIMEOUT_CYCLES = 5000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [UID_W-1:0]   user_id,
  input  logic [DIGIT_W-1:0] data_in,
  input  logic               data_in_load,
  output logic               access_grant,
  output logic               locked,
  output logic               busy,
  output logic [2:0]         status_frame
);
  localparam int PW_W = DIGIT_W * DIGITS;
  localparam int DCW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int LW   = $clog2(LOCK_CYCLES + 1);
  state_e            state_q, state_d;
  logic [UID_W-1:0]  uid_q, uid_d;
  logic [PW_W-1:0]   shreg_q, shreg_d, shifted, stored;
  logic [DCW-1:0]    dcnt_q, dcnt_d;
  logic [FW-1:0]     fail_q, fail_d;
  logic [LW-1:0]     lock_q, lock_d;
  logic              we, last, collecting, timeout, bad;
  assign shifted    = (shreg_q << DIGIT_W) | PW_W'(data_in);
  assign last       = dcnt_q == DCW'(DIGITS - 1);
  assign collecting = state_q == COLLECT || state_q == NEW_COLLECT;
`ifdef ACCESS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q;
  assign timeout = collecting && !data_in_load && tmr_q == '0;
  // Reload on every load and whenever the state changes, so each entry starts a fresh window
  always_ff @(posedge clk) begin
    if (rst) tmr_q <= TW'(TIMEOUT_CYCLES - 1);
    else tmr_q <= (collecting && state_d == state_q && !data_in_load) ? tmr_q - 1'b1 : TW'(TIMEOUT_CYCLES - 1);
  end
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    uid_d   = uid_q;
    shreg_d = shreg_q;
    dcnt_d  = dcnt_q;
    fail_d  = fail_q;
    lock_d  = lock_q;
    we      = 1'b0;
    bad     = 1'b0;
    case (state_q)
      IDLE: if (req == REQ_LOGIN) begin
        state_d = COLLECT;
        uid_d   = (int'(user_id) < USERS) ? user_id : '0;
        shreg_d = '0;
        dcnt_d  = '0;
      end
      COLLECT, NEW_COLLECT: begin
        if (data_in_load) begin
          shreg_d = shifted;
          dcnt_d  = last ? '0 : dcnt_q + 1'b1;
          we      = last && state_q == NEW_COLLECT;
          if (last) state_d = (state_q == COLLECT) ? CHECK : GRANTED;
        end else if (timeout) begin
          state_d = GRANTED;
          bad     = state_q == COLLECT;
        end
      end
      CHECK: begin
        bad = shreg_q != stored;
        if (!bad) begin
          state_d = GRANTED;
          fail_d  = '0;
        end
      end
      GRANTED: begin
        state_d = (req == REQ_LOGOUT) ? IDLE : (req == REQ_CHANGE) ? NEW_COLLECT : GRANTED;
        shreg_d = (req == REQ_CHANGE) ? '0 : shreg_q;
        dcnt_d  = (req == REQ_CHANGE) ? '0 : dcnt_q;
      end
      LOCKED: begin
        state_d = (lock_q == '0) ? IDLE : LOCKED;
        lock_d  = lock_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A failed attempt either escalates to lockout or bumps the global failure count
    if (bad) begin
      state_d = (fail_q + 1'b1 == FW'(MAX_FAILS)) ? LOCKED : IDLE;
      lock_d  = LW'(LOCK_CYCLES - 1);
      fail_d  = (fail_q + 1'b1 == FW'(MAX_FAILS)) ? '0 : fail_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      uid_q   <= '0;
      shreg_q <= '0;
      dcnt_q  <= '0;
      fail_q  <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      uid_q   <= uid_d;
      shreg_q <= shreg_d;
      dcnt_q  <= dcnt_d;
      fail_q  <= fail_d;
      lock_q  <= lock_d;
    end
  end
  access_pw_store #(
    .USERS(USERS), .PW_W(PW_W), .UID_W(UID_W), .DEFAULT_PW(DEFAULT_PW)
  ) u_store (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(uid_q), .wdata_i(shifted),
    .raddr_i(uid_q), .rdata_o(stored)
  );
  assign access_grant = state_q == GRANTED || state_q == NEW_COLLECT;
  assign locked       = state_q == LOCKED;
  assign busy         = collecting || state_q == CHECK;
  always_comb begin
    status_frame           = '0;
    status_frame[SF_GRANT] = access_grant;
    status_frame[SF_BUSY]  = busy;
    status_frame[SF_LOCK]  = locked;
  end
endmodule

// File: tb/tb_access_control_multi.sv
// tb_access_control_multi: randomized transaction-level check against a password/fail-count model
module tb_access_control_multi;
  localparam int USERS = 3, MAXF = 3, LOCKC = 8, TMO = 20;
  localparam logic [15:0] DEF = 16'h1234;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req = '0, user_id = '0;
  logic [3:0] data_in = '0;
  logic data_in_load = 1'b0;
  logic access_grant, locked, busy;
  logic [2:0] status_frame;
  int checks = 0, errors = 0;
  logic [15:0] mpw [USERS];
  int mfail, muid;
  bit granted;

  always #5 clk = ~clk;

  access_control_multi #(
    .DIGIT_W(4), .DIGITS(4), .USERS(USERS), .DEFAULT_PW(DEF),
    .MAX_FAILS(MAXF), .LOCK_CYCLES(LOCKC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .user_id(user_id), .data_in(data_in),
    .data_in_load(data_in_load), .access_grant(access_grant), .locked(locked),
    .busy(busy), .status_frame(status_frame)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input string tag, input logic [2:0] exp);
    check(tag, {26'b0, status_frame, locked, busy, access_grant}, {26'b0, exp, exp});
  endtask

  task automatic model_reset();
    foreach (mpw[i]) mpw[i] = DEF;
    mfail = 0;
    granted = 0;
  endtask

  task automatic enter(input logic [15:0] pw, input bit chg);
    for (int i = 3; i >= 0; i--) begin
      repeat ($urandom_range(0, 3)) begin
        req = 2'($urandom_range(0, 3));
        tick();
        frame("gap_busy", chg ? 3'b011 : 3'b010);
      end
      req = 2'($urandom_range(0, 3));
      data_in = pw[i*4 +: 4];
      data_in_load = 1'b1;
      tick();
      data_in_load = 1'b0;
      req = '0;
      if (i > 0) frame("digit_busy", chg ? 3'b011 : 3'b010);
    end
  endtask

  task automatic fail_outcome(input string tag);
    int n = 0;
    if (mfail + 1 == MAXF) begin
      mfail = 0;
      frame({tag, "_lock"}, 3'b100);
      while (locked && n < 100) begin
        n++;
        req = 2'b01;
        data_in_load = 1'b1;
        tick();
      end
      req = '0;
      data_in_load = 1'b0;
      check("lock_len", n, LOCKC);
      frame("lock_exit", 3'b000);
    end else begin
      mfail++;
      frame({tag, "_denied"}, 3'b000);
    end
  endtask

  task automatic login(input int uid, input logic [15:0] pw);
    int slot = (uid < USERS) ? uid : 0;
    req = 2'b01;
    user_id = 2'(uid);
    tick();
    req = '0;
    user_id = 2'($urandom);
    frame("login_busy", 3'b010);
    enter(pw, 0);
    frame("check_busy", 3'b010);
    data_in_load = 1'($urandom_range(0, 1));
    tick();
    data_in_load = 1'b0;
    if (pw == mpw[slot]) begin
      mfail = 0;
      granted = 1;
      muid = slot;
      frame("granted", 3'b001);
    end else fail_outcome("login");
  endtask

  task automatic change(input logic [15:0] pw);
    req = 2'b10;
    tick();
    req = '0;
    frame("chg_busy", 3'b011);
    enter(pw, 1);
    frame("chg_done", 3'b001);
    mpw[muid] = pw;
  endtask

  task automatic logout();
    req = 2'b11;
    tick();
    req = '0;
    granted = 0;
    frame("logout", 3'b000);
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    frame("reset", 3'b000);
    rst = 1'b0;
    login(2, 16'h1234); logout();
    login(0, 16'h1235);
    login(0, 16'h1234); logout();
    login(1, 16'h0000); login(1, 16'h0000); login(1, 16'h0000);
    login(1, 16'h1234);
    change(16'h9876); logout();
    login(1, 16'h1234);
    login(1, 16'h9876); logout();
    login(0, 16'h1234); logout();
    login(3, 16'h1234); logout();
    req = 2'b01;
    user_id = 2'd1;
    tick();
    req = '0;
    enter(16'h12ff, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    frame("rst_mid", 3'b000);
    login(1, 16'h1234); logout();
`ifdef ACCESS_TIMEOUT_EN
    req = 2'b01;
    user_id = 2'd0;
    tick();
    req = '0;
    data_in = 4'd1;
    data_in_load = 1'b1;
    tick();
    data_in_load = 1'b0;
    repeat (TMO - 1) tick();
    frame("tmo_wait", 3'b010);
    tick();
    fail_outcome("tmo");
    login(0, 16'h0000);
    login(0, 16'h0000);
`endif
    for (int k = 0; k < 60; k++) begin
      if (granted) begin
        int r = $urandom_range(0, 9);
        if (r < 3) logout();
        else if (r < 5) change($urandom_range(0, 1) ? DEF : 16'($urandom));
        else begin
          req = 2'($urandom_range(0, 1));
          tick();
          req = '0;
          frame("hold", 3'b001);
        end
      end else begin
        int u = $urandom_range(0, 3);
        login(u, $urandom_range(0, 2) != 0 ? mpw[(u < USERS) ? u : 0] : 16'($urandom));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
